// File: rtl/serial_subtractor_8.sv
// rtl/serial_subtractor_8.sv - bit-serial a - b - bin, LSB first, one bit per clock
// Single full-subtractor cell plus borrow flop; the result is held in a register apart from the working shifter.
module serial_subtractor_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             accept;
  logic             last;
  logic             d_bit;
  logic             brw_next;

  assign accept   = start && (state != RUN);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign d_bit    = a_sr[0] ^ b_sr[0] ^ brw;
  assign brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      brw     <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      brw     <= brw_next;
      diff_sr <= (WIDTH-1)'({d_bit, diff_sr} >> 1);
      cnt     <= cnt + 1'b1;
      // On the last step the operand LSBs are the original MSBs and d_bit is the result MSB.
      if (last) begin
        diff <= {d_bit, diff_sr};
        bout <= brw_next;
        ovf  <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8.sv
// tb/tb_serial_subtractor_8.sv - directed table-driven bench for serial_subtractor_8
module tb_serial_subtractor_8;

  localparam int W = 8;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         valid;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int checks;
  int errors;

  serial_subtractor_8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .valid (valid),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts an op at a negedge and returns at the negedge where valid is seen
  // (lat counts negedges after the accepting edge); operands are scrambled while running.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tbin, output int lat);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    lat = 1;
    chk("busy_after_accept", int'(busy), 1);
    while (!valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[$];
  int   lat;
  int   pulses;
  int   held_ok;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1});
    vecs.push_back('{8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0});

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_diff", int'(diff), 0);
    chk("reset_bout", int'(bout), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      chk($sformatf("v%0d_latency", i), lat, W + 1);
      chk($sformatf("v%0d_busy_in_done", i), int'(busy), 0);
      chk($sformatf("v%0d_diff", i), int'(diff), int'(vecs[i].diff));
      chk($sformatf("v%0d_bout", i), int'(bout), int'(vecs[i].bout));
      chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
      @(negedge clk);
      chk($sformatf("v%0d_valid_one_cycle", i), int'(valid), 0);
    end

    // start while RUN is ignored: one pulse, original result
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid) begin
        pulses++;
        chk("ignored_start_diff", int'(diff), 8'h02);
      end
      @(negedge clk);
    end
    chk("ignored_start_pulses", pulses, 1);

    // back-to-back: accept in the DONE cycle, old result held until the new one lands
    do_op(8'h05, 8'h03, 1'b0, lat);
    chk("b2b_first_diff", int'(diff), 8'h02);
    a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_again", int'(busy), 1);
    lat = 1;
    held_ok = 1;
    while (!valid && lat < TIMEOUT) begin
      if (diff != 8'h02) held_ok = 0;
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_held", held_ok, 1);
    chk("b2b_latency", lat, W + 1);
    chk("b2b_second_diff", int'(diff), 8'h05);

    // asynchronous reset mid-run
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_diff", int'(diff), 0);
    chk("midrst_bout", int'(bout), 0);
    chk("midrst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("midrst_no_valid", pulses, 0);
    do_op(8'h05, 8'h03, 1'b0, lat);
    chk("post_rst_latency", lat, W + 1);
    chk("post_rst_diff", int'(diff), 8'h02);
    chk("post_rst_bout", int'(bout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
